// File: rtl/stack_pkg.sv
// Shared encodings for the stack access controller: request opcodes and FSM states.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_TOS  = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_e;

endpackage

// File: rtl/stack_ram.sv
// Single-port stack RAM with synchronous read (read data one cycle after address).
module stack_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-during-write returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/stack_access_ctrl.sv
// Sequences push/pop/TOS requests onto an external single-port stack RAM,
// keeping the stack pointer and a top-of-stack cache so TOS needs no RAM read.
module stack_access_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              stack_empty,
    output logic              stack_full,
    output logic [ADDR_W:0]   depth,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W:0] SP_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] SP_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] SP_TWO  = (ADDR_W+1)'(2);

    state_e            state, state_nx;
    logic [ADDR_W:0]   sp, sp_nx;
    logic [DATA_W-1:0] tos_reg, tos_nx;
    logic              rsp_valid_nx, rsp_err_nx;
    logic [DATA_W-1:0] rsp_data_nx;
    logic [ADDR_W:0]   sp_m2;

    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_FULL);
    assign depth       = sp;
    assign sp_m2       = sp - SP_TWO;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sp        <= '0;
            tos_reg   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            sp        <= sp_nx;
            tos_reg   <= tos_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_data  <= rsp_data_nx;
            rsp_err   <= rsp_err_nx;
        end
    end

    // Next state, registered response and combinational RAM strobes.
    always_comb begin
        state_nx     = state;
        sp_nx        = sp;
        tos_nx       = tos_reg;
        rsp_valid_nx = 1'b0;
        rsp_data_nx  = '0;
        rsp_err_nx   = 1'b0;
        req_ready    = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = sp[ADDR_W-1:0];
        ram_wdata    = '0;

        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    case (req_op)
                        OP_PUSH: begin
                            rsp_valid_nx = 1'b1;
                            if (stack_full) begin
                                rsp_err_nx = 1'b1;
                            end else begin
                                ram_we      = 1'b1;
                                ram_wdata   = req_data;
                                sp_nx       = sp + SP_ONE;
                                tos_nx      = req_data;
                                rsp_data_nx = req_data;
                            end
                        end
                        OP_TOS: begin
                            rsp_valid_nx = 1'b1;
                            if (stack_empty) begin
                                rsp_err_nx = 1'b1;
                            end else begin
                                rsp_data_nx = tos_reg;
                            end
                        end
                        OP_POP: begin
                            rsp_valid_nx = 1'b1;
                            if (stack_empty) begin
                                rsp_err_nx = 1'b1;
                            end else if (sp == SP_ONE) begin
                                rsp_data_nx = tos_reg;
                                sp_nx       = '0;
                                tos_nx      = '0;
                            end else begin
                                // Fetch the new top (entry sp-2) while answering from the cache.
                                rsp_data_nx = tos_reg;
                                ram_addr    = sp_m2[ADDR_W-1:0];
                                sp_nx       = sp - SP_ONE;
                                state_nx    = S_REFILL;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_REFILL: begin
                tos_nx   = ram_rdata;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: doc/stack_access_ctrl.md
Name: stack_access_ctrl

Overview:
- Sequences push/pop/top-of-stack requests from the stack CPU controller onto a single-port, synchronous-read stack RAM.
- Owns the stack pointer, the empty/full flags and a top-of-stack cache register, so TOS is answered without a RAM read.
- Sits between the controller's push/pop/tos strobes and the stack RAM in the stack CPU datapath; serves one request at a time over a valid/ready handshake.

Parameters:
- DATA_W, 8, stack word width.
- DEPTH, 16, number of stack entries (power of two, ≥2).
- ADDR_W, clog2(DEPTH), derived localparam, RAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_op  in  2  request opcode: 00 NOP, 01 PUSH, 10 POP, 11 TOS.
- req_data  in  DATA_W  push operand.
- req_ready  out  1  controller can accept a request this cycle.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_W  pushed, popped or TOS value; 0 on error.
- rsp_err  out  1  overflow/underflow flag; valid only with rsp_valid.
- stack_empty  out  1  depth == 0.
- stack_full  out  1  depth == DEPTH.
- depth  out  ADDR_W+1  current entry count.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after the address is presented.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, sp=0, tos_reg=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - req_ready=1, stack_empty=1, stack_full=0, depth=0.
  - Reset mid-REFILL aborts the refill with no response.
- A request is accepted when req_valid & req_ready. At most one request per cycle.
- rsp_valid, rsp_data and rsp_err are registered and assert the cycle after acceptance (latency 1).
- FSM states: IDLE, REFILL.
- IDLE: req_ready=1. Behaviour on acceptance by opcode:
  - NOP: no state change, no response.
  - PUSH, not full: ram_we=1, ram_addr=sp, ram_wdata=req_data (combinational in the accept cycle). Then sp<=sp+1, tos_reg<=req_data. Response: rsp_data=req_data, rsp_err=0. Stay IDLE.
  - PUSH, full: ram_we=0, sp unchanged. Response: rsp_err=1, rsp_data=0.
  - TOS, not empty: no RAM access. Response: rsp_data=tos_reg, rsp_err=0.
  - TOS, empty: rsp_err=1, rsp_data=0.
  - POP, empty: rsp_err=1, rsp_data=0, sp unchanged.
  - POP, depth==1: response rsp_data=tos_reg; sp<=0, tos_reg<=0. Stay IDLE.
  - POP, depth≥2: response rsp_data=tos_reg; ram_addr=sp-2 (read) in the accept cycle; sp<=sp-1. Go to REFILL.
- REFILL (exactly one cycle):
  - req_ready=0, ram_we=0.
  - tos_reg<=ram_rdata. Go to IDLE.
  - The popped-value response pulses in this same cycle.
- Idle RAM outputs: ram_we=0 whenever no write; ram_addr holds sp when idle.
- Width rules:
  - sp is ADDR_W+1 bits and never wraps; full/empty checks gate every increment and decrement.
  - ram_addr takes the low ADDR_W bits.
  - depth equals sp.
- req_ready is a function of state only, not of req_valid.

Decomposition:
- Shared package stack_pkg:
  - req_op encodings (OP_NOP, OP_PUSH, OP_POP, OP_TOS).
  - FSM state encoding (S_IDLE, S_REFILL).
- No internal sub-module; the RAM is external.
- Companion stack_ram (single-port, synchronous read, DEPTH×DATA_W) is used by the bench and by the datapath integration.

Test Plan (DEPTH=4, DATA_W=8, stack_ram attached):
1. Hold rst=0, then release -> req_ready=1, stack_empty=1, stack_full=0, depth=0, rsp_valid=0.
2. PUSH 0x11, 0x22, 0x33 back-to-back -> three rsp_valid pulses with 0x11/0x22/0x33; depth=3. Then TOS -> rsp_data=0x33 next cycle, ram_we=0, no REFILL.
3. Three POPs from depth 3:
   - Responses 0x33, 0x22, 0x11.
   - req_ready=0 for one cycle after each of the first two pops, not after the third.
   - Ends with stack_empty=1.
4. Four PUSHes fill the stack (stack_full=1). A fifth PUSH 0xAA -> rsp_err=1, rsp_data=0, ram_we=0, depth stays 4. Then TOS returns the 4th value.
5. POP and TOS on an empty stack -> each gives rsp_err=1, rsp_data=0; depth stays 0. A NOP with req_valid=1 produces no rsp_valid.
6. Push 0x01, 0x02, POP, and drive rst=0 during REFILL -> all outputs take reset values immediately with no response pulse. After release, PUSH 0x5A then TOS -> 0x5A, depth=1.
